// File: rtl/lcd_host.sv
// lcd_host: image ROM, scripted command sequencer and result capture RAM serving the LCD controller.
module lcd_host (
  input  logic       clk,
  input  logic       reset,
  input  logic       img_we,
  input  logic [5:0] img_addr,
  input  logic [7:0] img_wdata,
  input  logic       scr_valid,
  input  logic [2:0] scr_data,
  output logic       scr_ready,
  input  logic       IROM_EN,
  input  logic [5:0] IROM_A,
  output logic [7:0] IROM_Q,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       busy,
  input  logic       IRB_RW,
  input  logic [5:0] IRB_A,
  input  logic [7:0] IRB_D,
  input  logic       done,
  input  logic [5:0] res_addr,
  output logic [7:0] res_data,
  output logic       all_written,
  output logic       finished
);
  typedef enum logic [2:0] {IDLE, LOADWAIT, FETCH, ISSUE, ACK, WAITIDLE, DRAIN, FINISH} state_t;
  state_t state, next;
  logic [7:0] rom [64];
  logic [7:0] res_ram [64];
  logic [63:0] written;
  logic [2:0] fifo [16];
  logic [3:0] wp, rp;
  logic [4:0] count;
  logic push, pop;
  assign scr_ready = count != 5'd16;
  assign push = scr_valid & scr_ready;
  assign pop = state == FETCH && count != 5'd0 && !busy;
  assign cmd_valid = state == ISSUE;
  assign all_written = &written;
  assign res_data = res_ram[res_addr];
  // storage arrays are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (img_we) rom[img_addr] <= img_wdata;
    if (push) fifo[wp] <= scr_data;
    if (!IRB_RW) res_ram[IRB_A] <= IRB_D;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      IROM_Q <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      cmd <= '0;
      finished <= 1'b0;
      written <= '0;
    end else begin
      state <= next;
      if (!IROM_EN) IROM_Q <= rom[IROM_A];
      if (push) wp <= wp + 4'd1;
      if (pop) rp <= rp + 4'd1;
      if (pop) cmd <= fifo[rp];
      count <= count + {4'd0, push} - {4'd0, pop};
      if (state == DRAIN && done) finished <= 1'b1;
      if (!IRB_RW) written[IRB_A] <= 1'b1;
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = LOADWAIT;
      LOADWAIT: next = IROM_EN ? FETCH : LOADWAIT;
      FETCH:    next = pop ? ISSUE : FETCH;
      ISSUE:    next = ACK;
      ACK:      next = !busy ? ACK : (cmd == 3'd0 ? DRAIN : WAITIDLE);
      WAITIDLE: next = busy ? WAITIDLE : FETCH;
      DRAIN:    next = done ? FINISH : DRAIN;
      default:  next = FINISH;
    endcase
  end
endmodule

// File: tb/tb_lcd_host.sv
// tb_lcd_host: self-checking bench for lcd_host using queue/array reference models and a simple busy responder.
module tb_lcd_host;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic img_we = 1'b0;
  logic [5:0] img_addr = '0;
  logic [7:0] img_wdata = '0;
  logic scr_valid = 1'b0;
  logic [2:0] scr_data = '0;
  logic scr_ready;
  logic IROM_EN = 1'b0;
  logic [5:0] IROM_A = '0;
  logic [7:0] IROM_Q;
  logic [2:0] cmd;
  logic cmd_valid;
  logic busy = 1'b1;
  logic IRB_RW = 1'b1;
  logic [5:0] IRB_A = '0;
  logic [7:0] IRB_D = '0;
  logic done = 1'b0;
  logic [5:0] res_addr = '0;
  logic [7:0] res_data;
  logic all_written;
  logic finished;

  always #5 clk = ~clk;

  lcd_host dut (
    .clk(clk), .reset(reset), .img_we(img_we), .img_addr(img_addr), .img_wdata(img_wdata),
    .scr_valid(scr_valid), .scr_data(scr_data), .scr_ready(scr_ready),
    .IROM_EN(IROM_EN), .IROM_A(IROM_A), .IROM_Q(IROM_Q),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
    .IRB_RW(IRB_RW), .IRB_A(IRB_A), .IRB_D(IRB_D), .done(done),
    .res_addr(res_addr), .res_data(res_data), .all_written(all_written), .finished(finished)
  );

  typedef struct { logic v; logic [2:0] d; logic ready; } vec_t;
  vec_t tv [17];
  logic [7:0] rom_m [64];
  logic [7:0] res_m [64];
  logic [2:0] exp_q [$];
  logic [2:0] exp_cmd = '0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] d);
    scr_valid = 1'b1;
    scr_data = d;
    if (exp_q.size() < 16) exp_q.push_back(d);
    step();
    scr_valid = 1'b0;
  endtask

  // Runs a fixed number of cycles with a controller-like busy response; every
  // pulse must match the script order, be single-cycle and keep 4-cycle spacing.
  task automatic serve(input int n, input int cycles, input bit imm);
    int got = 0;
    int last_c = -10;
    int ph = -1;
    int h = 1;
    int e;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (c == 0 && imm) check("pulse_after_busy_low", cmd_valid, 1);
      if (cmd_valid) begin
        check("pulse_gap", int'(c - last_c >= 4), 1);
        if (exp_q.size() > 0) e = int'(exp_q.pop_front());
        else e = -1;
        check("cmd_order", cmd, e);
        exp_cmd = cmd;
        last_c = c;
        got++;
        ph = 0;
        h = $urandom_range(1, 3);
      end else begin
        check("cmd_stable", cmd, exp_cmd);
        if (ph >= 0) begin
          ph++;
          if (ph == 1) busy = 1'b1;
          if (ph == 1 + h) begin
            busy = 1'b0;
            ph = -1;
          end
        end
      end
    end
    check("pulses_served", got, n);
  endtask

  initial begin
    int ok;
    logic [2:0] a0;
    for (int i = 0; i < 17; i++) tv[i] = '{1'b1, 3'($urandom_range(1, 7)), 1'(i < 16)};
    for (int i = 0; i < 64; i++) rom_m[i] = 8'($urandom);
    step();
    step();
    check("rst_IROM_Q", IROM_Q, 0);
    check("rst_cmd", cmd, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_finished", finished, 0);
    check("rst_all_written", all_written, 0);
    check("rst_scr_ready", scr_ready, 1);
    for (int i = 0; i < 64; i++) begin
      img_we = 1'b1;
      img_addr = 6'(i);
      img_wdata = rom_m[i];
      step();
    end
    img_we = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      IROM_A = 6'(i);
      step();
      check("rom_sweep", IROM_Q, rom_m[i]);
    end
    IROM_A = 6'd5;
    img_we = 1'b1;
    img_addr = 6'd5;
    img_wdata = ~rom_m[5];
    step();
    check("rom_same_cycle_old", IROM_Q, rom_m[5]);
    img_we = 1'b0;
    rom_m[5] = ~rom_m[5];
    step();
    check("rom_new_data", IROM_Q, rom_m[5]);
    IROM_A = 6'd63;
    step();
    IROM_EN = 1'b1;
    IROM_A = 6'd2;
    step();
    step();
    check("rom_hold", IROM_Q, rom_m[63]);
    for (int i = 0; i < 17; i++) begin
      check("fifo_ready", scr_ready, tv[i].ready);
      scr_valid = tv[i].v;
      scr_data = tv[i].d;
      if (exp_q.size() < 16) exp_q.push_back(tv[i].d);
      step();
    end
    scr_valid = 1'b0;
    check("fifo_full_ready", scr_ready, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_issue_while_busy", cmd_valid, 0);
    end
    busy = 1'b0;
    check("no_pulse_before_pop", cmd_valid, 0);
    serve(16, 130, 1'b1);
    busy = 1'b1;
    push(3'd0);
    push(3'd3);
    busy = 1'b0;
    serve(1, 12, 1'b1);
    IRB_RW = 1'b0;
    IRB_A = 6'd7;
    IRB_D = 8'($urandom);
    step();
    for (int i = 0; i < 64; i++) begin
      IRB_A = 6'(i);
      IRB_D = 8'(i + 1);
      res_m[i] = 8'(i + 1);
      step();
      if (i == 62) check("all_written_early", all_written, 0);
    end
    IRB_RW = 1'b1;
    check("all_written", all_written, 1);
    check("finished_before_done", finished, 0);
    done = 1'b1;
    step();
    done = 1'b0;
    check("finished_after_done", finished, 1);
    serve(0, 10, 1'b0);
    check("finished_sticky", finished, 1);
    for (int k = 0; k < 64; k++) begin
      res_addr = 6'(k);
      #1;
      check("res_data", res_data, res_m[k]);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    exp_cmd = '0;
    check("rst2_finished", finished, 0);
    check("rst2_all_written", all_written, 0);
    check("rst2_cmd", cmd, 0);
    busy = 1'b1;
    a0 = 3'($urandom_range(1, 7));
    push(a0);
    push(3'($urandom_range(1, 7)));
    busy = 1'b0;
    ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin
      step();
      ok = int'(cmd_valid);
    end
    check("ack_test_pulse", ok, 1);
    check("ack_test_cmd", cmd, a0);
    step();
    check("ack_single_cycle", cmd_valid, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    exp_cmd = '0;
    check("rst3_cmd_valid", cmd_valid, 0);
    check("rst3_cmd", cmd, 0);
    check("rst3_scr_ready", scr_ready, 1);
    check("rst3_finished", finished, 0);
    IROM_EN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      IROM_A = 6'($urandom_range(0, 63));
      step();
      check("rom_preserved", IROM_Q, rom_m[IROM_A]);
    end
    IROM_EN = 1'b1;
    serve(0, 10, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
